// File: rtl/scratchpad_backdoor_arbiter.sv
// Scratchpad backdoor arbiter: round-robin arbitration of several backdoor
// requesters (printf engine, DPI read/write, ...) onto a single scratchpad
// port, one transaction outstanding at a time.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no transaction; round-robin grant pulses req_ready[w]
// ISSUE  | scratchpad access driven (write strobe or read address)
// RDWAIT | read address held; registered read data captured at cycle end
// RESP   | rsp_valid[w] pulse; back to IDLE
module scratchpad_backdoor_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic [NUM_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]           rsp_rdata,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic                        mem_write,
  output logic [DATA_W/8-1:0]         mem_mask,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic                        busy
);

  localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int MASK_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RDWAIT = 2'd2,
    RESP   = 2'd3
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   last_grant;
  logic [IDX_W-1:0]   cur_id;
  logic               cur_write;

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Byte offset within the 8-byte word is dropped on purpose.
  logic               unused_addr_lsb;

  // Requester index offset positions past base, wrapping modulo NUM_REQ.
  function automatic logic [IDX_W-1:0] rr_index(input logic [IDX_W-1:0] base,
                                                  input int offset);
    int sum;
    sum = (int'(base) + offset) % NUM_REQ;
    return IDX_W'(sum);
  endfunction

  // Round-robin search starting one past the previous winner.
  always_comb begin
    found  = 1'b0;
    winner = last_grant;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req_valid[rr_index(last_grant, i)]) begin
        found  = 1'b1;
        winner = rr_index(last_grant, i);
      end
    end
  end

  // Fields of the winning requester.
  always_comb begin
    sel_write = req_write[winner];
    sel_addr  = req_addr[int'(winner)*ADDR_W +: ADDR_W];
    sel_wdata = req_wdata[int'(winner)*DATA_W +: DATA_W];
  end

  assign unused_addr_lsb = ^sel_addr[2:0];

  // Accept pulse is only possible in IDLE, and never while reset is held.
  always_comb begin
    req_ready = '0;
    if (state == IDLE && found && !rst) begin
      req_ready[winner] = 1'b1;
    end
  end

  // Transaction sequencer with registered scratchpad and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= IDX_W'(NUM_REQ - 1);
      cur_id     <= '0;
      cur_write  <= 1'b0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      mem_addr   <= '0;
      mem_write  <= 1'b0;
      mem_mask   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        IDLE: begin
          if (found) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            last_grant <= winner;
            cur_id     <= winner;
            cur_write  <= sel_write;
            mem_addr   <= {sel_addr[ADDR_W-1:3], 3'b000};
            mem_write  <= sel_write;
            mem_mask   <= {MASK_W{sel_write}};
            mem_wdata  <= sel_wdata & {DATA_W{sel_write}};
          end
        end
        ISSUE: begin
          mem_write <= 1'b0;
          mem_mask  <= '0;
          mem_wdata <= '0;
          if (cur_write) begin
            mem_addr          <= '0;
            rsp_valid[cur_id] <= 1'b1;
            state             <= RESP;
          end else begin
            state <= RDWAIT;
          end
        end
        RDWAIT: begin
          mem_addr          <= '0;
          rsp_rdata         <= mem_rdata;
          rsp_valid[cur_id] <= 1'b1;
          state             <= RESP;
        end
        RESP: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/scratchpad_backdoor_arbiter.md
SCRATCHPAD_BACKDOOR_ARBITER -- requirements
Module: scratchpad_backdoor_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of backdoor requesters (printf engine, DPI read/write, others).
REQ-002 SHALL have parameter ADDR_W, default 32: request address width.
REQ-003 SHALL have parameter DATA_W, default 64: data width; byte-mask width is DATA_W/8.
REQ-004 SHALL have port clk  in  1: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst  in  1: reset, asynchronous and active-high.
REQ-006 SHALL have port req_valid  in  NUM_REQ: per-requester request.
REQ-007 SHALL have port req_write  in  NUM_REQ: 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  in  NUM_REQ*ADDR_W: packed byte addresses; requester i uses slice i.
REQ-009 SHALL have port req_wdata  in  NUM_REQ*DATA_W: packed write data.
REQ-010 SHALL have port req_ready  out  NUM_REQ: one-cycle accept pulse.
REQ-011 SHALL have port rsp_valid  out  NUM_REQ: one-cycle completion pulse.
REQ-012 SHALL have port rsp_rdata  out  DATA_W: shared read-data register.
REQ-013 SHALL have port mem_addr  out  ADDR_W: scratchpad address.
REQ-014 SHALL have port mem_write  out  1: scratchpad write strobe.
REQ-015 SHALL have port mem_mask  out  DATA_W/8: byte mask.
REQ-016 SHALL have port mem_wdata  out  DATA_W: scratchpad write data.
REQ-017 SHALL have port mem_rdata  in  DATA_W: registered scratchpad read data, valid one cycle after mem_addr.
REQ-018 SHALL have port busy  out  1: high whenever the FSM is not in IDLE.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, RDWAIT, RESP.
REQ-020 IDLE, any req_valid high: SHALL choose winner w by round-robin, searching from last_grant+1 mod NUM_REQ; pulse req_ready[w]; latch write, address and data; update last_grant to w; go to ISSUE.
REQ-021 IDLE, no req_valid: SHALL stay in IDLE.
REQ-022 ISSUE: SHALL drive mem_addr = {latched addr[ADDR_W-1:3], 3'b000}, so addr[2:0] is ignored.
REQ-023 ISSUE, write: SHALL assert mem_write=1, mem_mask all-ones and mem_wdata = latched data; next state RESP.
REQ-024 ISSUE, read: SHALL hold mem_write=0 and mem_mask=0; next state RDWAIT.
REQ-025 RDWAIT: SHALL hold mem_addr and capture mem_rdata into rsp_rdata at the end of the cycle; next state RESP.
REQ-026 RESP: SHALL pulse rsp_valid[w] for one cycle; next state IDLE.
REQ-027 Latency, accept at cycle T:
- write: mem_write high at T+1; rsp_valid at T+2.
- read: mem_addr valid at T+1; rsp_rdata updated and rsp_valid at T+3.
REQ-028 Outside ISSUE/RDWAIT: mem_addr, mem_write, mem_mask and mem_wdata SHALL be 0.
REQ-029 rsp_rdata SHALL change only on a read capture; writes leave it unchanged.
REQ-030 Request hold rule:
- requester SHALL hold req_valid and its fields until req_ready;
- dropping req_valid before req_ready is a legal withdrawal and SHALL produce no transaction.
REQ-031 A requester SHALL NOT be granted again until its rsp_valid has pulsed; at most one transaction is outstanding.
REQ-032 req_valid asserted during ISSUE, RDWAIT or RESP SHALL be ignored until the next IDLE cycle; the earliest new grant is the cycle after RESP.
REQ-033 At most one bit of req_ready and at most one bit of rsp_valid SHALL be high in any cycle.

Reset
REQ-034 rst high SHALL immediately force: state IDLE; last_grant = NUM_REQ-1; req_ready, rsp_valid, rsp_rdata, mem_* outputs and busy all 0.
REQ-035 rst during ISSUE/RDWAIT/RESP SHALL abort the transaction with no rsp_valid; a write aborted in ISSUE may leave memory unmodified.
REQ-036 First grant after reset release SHALL go to the lowest-index requesting port.

Verification
REQ-037 Write: req0, addr 0x80000008, data 0x1122334455667788 -> req_ready[0] at T; mem_write=1, mem_mask=0xFF, mem_addr=0x80000008 at T+1; rsp_valid[0] at T+2.
REQ-038 Read: req2, addr 0x80000013; memory model returns 0xDEADBEEFCAFEF00D -> mem_addr=0x80000010 at T+1 and T+2; rsp_rdata=0xDEADBEEFCAFEF00D with rsp_valid[2] at T+3.
REQ-039 Fairness: all four request from reset -> grant order 0,1,2,3; then requests on 0 and 3 -> order 0 then 3.
REQ-040 Reset mid-read: rst pulsed in RDWAIT -> all outputs 0 in the same cycle; no rsp_valid; rsp_rdata=0; next request on port 1 is granted normally.
REQ-041 Withdrawal: req1 drops while req0 is in service -> only req0 completes; busy falls after RESP; no req_ready[1].
REQ-042 Throughput: back-to-back writes from req3 -> req_ready[3] every 3 cycles; reads -> every 4 cycles.
